dac_bus_monitor: RTL and testbench

- Loop-back checker for the two-channel 14-bit DAC data bus driven by the DDS generator (Data1/WRT1, Data2/WRT2).
- Each channel captures the samples qualified by its WRT strobe and measures min, max, rising midscale-crossing count and period over fixed sample windows.
- Measurement records are emitted on one valid/ready result port for a host readout path.
- Sits in the Clk domain beside the DDS module, tapping the same bus.

---
 rtl/dac_bus_monitor_pkg.sv | 39 +++
 rtl/dac_bus_monitor_if.sv | 29 ++
 rtl/dac_chan_monitor.sv | 94 +++++++++
 rtl/dac_bus_monitor.sv | 74 +++++++
 tb/tb_dac_bus_monitor.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/dac_bus_monitor_pkg.sv
// Shared definitions for the DAC bus loop-back monitor: widths, thresholds,
// channel IDs, channel FSM encoding and the packed measurement record.
package dac_bus_monitor_pkg;

  localparam int DATA_W       = 14;
  localparam int MID          = 8192;
  localparam int HYST         = 64;
  localparam int CNT_W        = 20;
  localparam int WIN_LOG2_DEF = 16;

  // Hysteresis thresholds around midscale, in sample codes
  localparam logic [DATA_W-1:0] LO_THR = DATA_W'(MID - HYST);
  localparam logic [DATA_W-1:0] HI_THR = DATA_W'(MID + HYST);

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } chan_state_t;

  // Record bit order, MSB first: {Ovf, Period, Edges, Max, Min}
  typedef struct packed {
    logic              ovf;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  edges;
    logic [DATA_W-1:0] vmax;
    logic [DATA_W-1:0] vmin;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  // Saturating increment for the edge and period counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dac_bus_monitor_if.sv
// Bus tapped by the monitor: both DAC channels plus the result handshake.
// master = DDS side / host reader, slave = the monitor.
interface dac_bus_monitor_if;
  import dac_bus_monitor_pkg::*;

  logic [DATA_W-1:0] Data1;
  logic              WRT1;
  logic [DATA_W-1:0] Data2;
  logic              WRT2;
  logic              Res_Ready;
  logic              Res_Valid;
  logic              Res_Chan;
  logic [DATA_W-1:0] Res_Min;
  logic [DATA_W-1:0] Res_Max;
  logic [CNT_W-1:0]  Res_Edges;
  logic [CNT_W-1:0]  Res_Period;
  logic              Res_Ovf;

  modport master (
    output Data1, WRT1, Data2, WRT2, Res_Ready,
    input  Res_Valid, Res_Chan, Res_Min, Res_Max, Res_Edges, Res_Period, Res_Ovf
  );

  modport slave (
    input  Data1, WRT1, Data2, WRT2, Res_Ready,
    output Res_Valid, Res_Chan, Res_Min, Res_Max, Res_Edges, Res_Period, Res_Ovf
  );

endinterface

// File: rtl/dac_chan_monitor.sv
// One DAC channel: windowed min/max, hysteretic rising-crossing count,
// crossing period, and a single-entry pending slot for the closed record.
module dac_chan_monitor
  import dac_bus_monitor_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_wrt,
  input  logic              i_drain,
  output logic              o_pend,
  output rec_t              o_rec
);

  chan_state_t         r_state;
  logic [DATA_W-1:0]   r_min, r_max;
  logic [WIN_LOG2-1:0] r_cnt;
  logic [CNT_W-1:0]    r_edges, r_per, r_plast;
  logic                r_below, r_pend;
  rec_t                r_slot;

  logic                w_first, w_lo, w_cross, w_close;
  logic [DATA_W-1:0]   w_min, w_max;
  logic [CNT_W-1:0]    w_edges_b, w_per_b, w_per_inc, w_per_n, w_edges, w_plast;
  rec_t                w_rec;

  // Next-state values for a qualified sample; the first sample of a window
  // starts from fresh accumulators so no gap cycle is needed between windows
  always_comb begin
    w_first   = (r_state == ST_IDLE);
    w_lo      = (i_data <= LO_THR);
    w_cross   = r_below && (i_data >= HI_THR);
    // r_cnt holds samples already in the window; all-ones means this one closes it
    w_close   = (r_cnt == '1);
    w_min     = (w_first || i_data < r_min) ? i_data : r_min;
    w_max     = (w_first || i_data > r_max) ? i_data : r_max;
    w_edges_b = w_first ? '0 : r_edges;
    w_per_b   = w_first ? '0 : r_per;
    // Period counts only once a crossing has been seen; the crossing sample
    // itself is included so period = distance between crossing samples
    w_per_inc = (w_edges_b != '0) ? sat_inc(w_per_b) : w_per_b;
    w_edges   = w_cross ? sat_inc(w_edges_b) : w_edges_b;
    w_plast   = w_cross ? w_per_inc : (w_first ? '0 : r_plast);
    w_per_n   = w_cross ? '0 : w_per_inc;
    w_rec        = '0;
    w_rec.ovf    = r_pend & ~i_drain;
    w_rec.period = (w_edges >= CNT_W'(2)) ? w_plast : '0;
    w_rec.edges  = w_edges;
    w_rec.vmax   = w_max;
    w_rec.vmin   = w_min;
  end

  // Channel FSM, accumulators, below flag and pending slot
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_state <= ST_IDLE;
      r_min   <= '0;
      r_max   <= '0;
      r_cnt   <= '0;
      r_edges <= '0;
      r_per   <= '0;
      r_plast <= '0;
      r_below <= 1'b0;
      r_pend  <= 1'b0;
      r_slot  <= '0;
    end else begin
      if (i_wrt) begin
        r_min   <= w_min;
        r_max   <= w_max;
        r_edges <= w_edges;
        r_per   <= w_per_n;
        r_plast <= w_plast;
        r_cnt   <= r_cnt + 1'b1;
        if (w_lo)         r_below <= 1'b1;
        else if (w_cross) r_below <= 1'b0;
        r_state <= w_close ? ST_IDLE : ST_ACCUM;
      end
      // A close replaces any unread record; a same-edge drain is not an overwrite
      if (i_wrt && w_close) begin
        r_slot <= w_rec;
        r_pend <= 1'b1;
      end else if (i_drain) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_pend = r_pend;
  assign o_rec  = r_slot;

endmodule

// File: rtl/dac_bus_monitor.sv
// Two-channel DAC bus monitor: per-channel measurement plus a single output
// register fed from the pending slots with fixed channel-0 priority.
module dac_bus_monitor
  import dac_bus_monitor_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Clear,
  dac_bus_monitor_if.slave   bus
);

  logic [1:0]        w_pend, w_drain, w_wrt;
  logic [DATA_W-1:0] w_data [2];
  rec_t              w_rec  [2];
  logic              w_take;

  logic              r_valid, r_chan;
  rec_t              r_rec;

  assign w_data[0] = bus.Data1;
  assign w_wrt[0]  = bus.WRT1;
  assign w_data[1] = bus.Data2;
  assign w_wrt[1]  = bus.WRT2;

  // Output register can take a record when empty or being accepted this edge
  assign w_take     = ~r_valid | bus.Res_Ready;
  assign w_drain[0] = w_take & w_pend[0];
  assign w_drain[1] = w_take & w_pend[1] & ~w_pend[0];

  for (genvar c = 0; c < 2; c++) begin : g_ch
    dac_chan_monitor #(.WIN_LOG2(WIN_LOG2)) u_ch (
      .clk     (Clk),
      .rst_n   (Reset_n),
      .i_clear (Clear),
      .i_data  (w_data[c]),
      .i_wrt   (w_wrt[c]),
      .i_drain (w_drain[c]),
      .o_pend  (w_pend[c]),
      .o_rec   (w_rec[c])
    );
  end

  // Result register and valid/ready handshake
  always_ff @(posedge Clk) begin
    if (!Reset_n || Clear) begin
      r_valid <= 1'b0;
      r_chan  <= CH0;
      r_rec   <= '0;
    end else if (w_take) begin
      if (w_pend[0]) begin
        r_valid <= 1'b1;
        r_chan  <= CH0;
        r_rec   <= w_rec[0];
      end else if (w_pend[1]) begin
        r_valid <= 1'b1;
        r_chan  <= CH1;
        r_rec   <= w_rec[1];
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.Res_Valid  = r_valid;
  assign bus.Res_Chan   = r_chan;
  assign bus.Res_Min    = r_rec.vmin;
  assign bus.Res_Max    = r_rec.vmax;
  assign bus.Res_Edges  = r_rec.edges;
  assign bus.Res_Period = r_rec.period;
  assign bus.Res_Ovf    = r_rec.ovf;

endmodule

// File: tb/tb_dac_bus_monitor.sv
// Scoreboard bench for dac_bus_monitor with 16-sample windows.
module tb_dac_bus_monitor;
  import dac_bus_monitor_pkg::*;

  localparam int WL  = 4;
  localparam int WIN = 1 << WL;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic Clear = 1'b0;
  always #5 Clk = ~Clk;

  dac_bus_monitor_if bus();

  dac_bus_monitor #(.WIN_LOG2(WL)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Clear   (Clear),
    .bus     (bus)
  );

  typedef struct {
    int ch; int mn; int mx; int edges; int period; int ovf;
  } exp_t;

  exp_t q[$];
  int   smp [2][WIN];
  int   nsmp [2];
  bit   below [2];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void check(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: collect a window of samples, then evaluate it in one go
  function automatic void model_rst();
    nsmp[0] = 0; nsmp[1] = 0;
    below[0] = 0; below[1] = 0;
    q.delete();
  endfunction

  function automatic void model_sample(int ch, int v);
    exp_t e;
    int last, prev;
    smp[ch][nsmp[ch]] = v;
    nsmp[ch]++;
    if (nsmp[ch] == WIN) begin
      e.ch = ch; e.mn = smp[ch][0]; e.mx = smp[ch][0]; e.edges = 0; e.ovf = 0;
      last = -1; prev = -1;
      for (int i = 0; i < WIN; i++) begin
        if (smp[ch][i] < e.mn) e.mn = smp[ch][i];
        if (smp[ch][i] > e.mx) e.mx = smp[ch][i];
        if (smp[ch][i] <= MID - HYST) below[ch] = 1;
        else if (below[ch] && smp[ch][i] >= MID + HYST) begin
          below[ch] = 0; e.edges++; prev = last; last = i;
        end
      end
      e.period = (e.edges >= 2) ? last - prev : 0;
      q.push_back(e);
      nsmp[ch] = 0;
    end
  endfunction

  // Drive one cycle of stimulus; the DUT samples it on the following edge
  task automatic drive(input bit w1, input int d1, input bit w2, input int d2,
                       input bit rdy, input bit clr = 0, input bit rn = 1);
    @(posedge Clk); #1;
    bus.Data1 = d1[DATA_W-1:0]; bus.WRT1 = w1;
    bus.Data2 = d2[DATA_W-1:0]; bus.WRT2 = w2;
    bus.Res_Ready = rdy; Clear = clr; Reset_n = rn;
    if (clr || !rn) model_rst();
    else begin
      if (w1) model_sample(0, d1);
      if (w2) model_sample(1, d2);
    end
  endtask

  function automatic int rnd_data();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 8000));
      1:       return int'($urandom_range(8400, 16383));
      2:       return int'($urandom_range(8100, 8300));
      default: return int'($urandom_range(0, 16383));
    endcase
  endfunction

  // Monitor: compare each accepted record; check stability while stalled
  initial begin
    logic [127:0] snap, cur;
    bit hold;
    exp_t e;
    hold = 0; snap = '0;
    forever begin
      @(negedge Clk);
      cur = {bus.Res_Chan, bus.Res_Min, bus.Res_Max, bus.Res_Edges, bus.Res_Period, bus.Res_Ovf};
      if (!Reset_n || Clear) begin
        hold = 0;
      end else begin
        if (hold && bus.Res_Valid === 1'b1) check("stable_while_stalled", cur, snap);
        hold = 0;
        if (bus.Res_Valid === 1'b1 && bus.Res_Ready === 1'b0) begin
          hold = 1; snap = cur;
        end else if (bus.Res_Valid === 1'b1 && bus.Res_Ready === 1'b1) begin
          if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_record: chan %0d min %0d max %0d (t=%0t)",
                     bus.Res_Chan, bus.Res_Min, bus.Res_Max, $time);
          end else begin
            e = q.pop_front();
            check("chan",   bus.Res_Chan,   e.ch);
            check("min",    bus.Res_Min,    e.mn);
            check("max",    bus.Res_Max,    e.mx);
            check("edges",  bus.Res_Edges,  e.edges);
            check("period", bus.Res_Period, e.period);
            check("ovf",    bus.Res_Ovf,    e.ovf);
          end
        end
      end
    end
  end

  initial begin
    exp_t e;
    int v;
    bus.Data1 = '0; bus.WRT1 = 0; bus.Data2 = '0; bus.WRT2 = 0; bus.Res_Ready = 0;
    model_rst();

    // 1: reset held with WRT toggling, then 20 quiet-output cycles
    for (int i = 0; i < 10; i++) begin
      drive(i[0], 100, i[0], 9000, 1, 0, 0);
      @(negedge Clk);
      check("reset_outputs_zero",
            {bus.Res_Valid, bus.Res_Chan, bus.Res_Min, bus.Res_Max, bus.Res_Edges,
             bus.Res_Period, bus.Res_Ovf}, 0);
    end
    for (int i = 0; i < 20; i++) begin
      drive(i[0], 100, i[0], 9000, 1);
      @(negedge Clk);
      check("no_record_before_window", bus.Res_Valid, 0);
    end
    for (int i = 0; i < 6; i++) drive(1, 100, 1, 9000, 1);
    repeat (6) drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 1);

    // 2: constant 1000, then verify one-cycle latency after the closing edge
    for (int i = 0; i < WIN; i++) drive(1, 1000, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    @(negedge Clk);
    check("valid_not_on_close_edge", bus.Res_Valid, 0);
    drive(0, 0, 0, 0, 1);
    @(negedge Clk);
    check("valid_one_after_close", bus.Res_Valid, 1);
    repeat (4) drive(0, 0, 0, 0, 1);

    // 3: square wave, dense then with WRT1 low every other cycle
    for (int i = 0; i < WIN; i++) drive(1, ((i / 4) % 2) ? 16383 : 0, 0, 0, 1);
    for (int i = 0; i < 2 * WIN; i++) begin
      v = i / 2;
      if (i[0]) drive(0, 8192, 0, 0, 1);
      else      drive(1, ((v / 4) % 2) ? 16383 : 0, 0, 0, 1);
    end
    repeat (4) drive(0, 0, 0, 0, 1);

    // 4: both channels close on the same edge
    for (int i = 0; i < WIN; i++) drive(1, 5000, 1, i[0] ? 16000 : 100, 1);
    repeat (4) drive(0, 0, 0, 0, 1);

    // 5: three channel-0 windows while stalled; window 2 is overwritten
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < WIN; i++) drive(1, 1000 * (k + 1) + i, 0, 0, 0);
      if (k == 1) e = q.pop_back();
      if (k == 2) begin
        e = q.pop_back(); e.ovf = 1; q.push_back(e);
      end
    end
    repeat (5) drive(0, 0, 0, 0, 0);
    repeat (6) drive(0, 0, 0, 0, 1);

    // 6: reset mid-window discards the partial window
    for (int i = 0; i < 10; i++) drive(1, 3000, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < WIN; i++) drive(1, 500, 0, 0, 1);
    repeat (4) drive(0, 0, 0, 0, 1);

    // Random traffic, both channels, occasional Clear
    for (int i = 0; i < 1500; i++)
      drive(1'($urandom_range(0, 1)), rnd_data(), 1'($urandom_range(0, 1)), rnd_data(),
            1, ($urandom_range(0, 299) == 0));
    repeat (6) drive(0, 0, 0, 0, 1);

    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
